// File: rtl/riscv_core_mul_pkg.sv
// Shared decode for the multiplier output stages: the control encoding
// and the rule deciding whether the magnitude product must be negated.
package riscv_core_mul_pkg;

  typedef logic [1:0] mul_ctrl_t;

  localparam mul_ctrl_t CTRL_MUL    = 2'b00;
  localparam mul_ctrl_t CTRL_MULH   = 2'b01;
  localparam mul_ctrl_t CTRL_MULHSU = 2'b10;
  localparam mul_ctrl_t CTRL_MULHU  = 2'b11;
  localparam logic      ISWORD_MULW = 1'b1;

  // Word mode is always MULW, whatever control code accompanies it.
  function automatic logic mul_negate(input mul_ctrl_t ctrl, input logic isword,
                                      input logic sign_a, input logic sign_b);
    logic neg;
    if (isword == ISWORD_MULW) begin
      neg = sign_a ^ sign_b;
    end else begin
      case (ctrl)
        CTRL_MUL, CTRL_MULH: neg = sign_a ^ sign_b;
        CTRL_MULHSU:         neg = sign_a;
        default:             neg = 1'b0;
      endcase
    end
    return neg;
  endfunction

endpackage

// File: rtl/riscv_core_mul_neg_half.sv
// Conditional two's-complement negate of one half of the product:
// o_data = negate ? ~i_data + carry_in : i_data, with the carry out of that sum.
module riscv_core_mul_neg_half #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_data,
  input  logic         i_negate,
  input  logic         i_carry,
  output logic [W-1:0] o_data,
  output logic         o_carry
);

  logic [W:0] w_sum;

  assign w_sum   = {1'b0, ~i_data} + {{W{1'b0}}, i_carry};
  assign o_data  = i_negate ? w_sum[W-1:0] : i_data;
  assign o_carry = i_negate & w_sum[W];

endmodule

// File: rtl/riscv_core_mul_out.sv
// Two-stage valid/ready output conditioning for the M-extension multiplier:
// low-half negate in stage 1, high-half negate with registered carry in stage 2.
module riscv_core_mul_out
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              i_mul_out_clk,
  input  logic              i_mul_out_rst_n,
  input  logic              i_mul_out_valid,
  output logic              o_mul_out_ready,
  input  logic [2*XLEN-1:0] i_mul_out_product,
  input  mul_ctrl_t         i_mul_out_control,
  input  logic              i_mul_out_isword,
  input  logic              i_mul_out_signA,
  input  logic              i_mul_out_signB,
  output logic              o_mul_out_valid,
  input  logic              i_mul_out_ready,
  output logic [XLEN-1:0]   o_mul_out_result
);

  localparam int HALF = XLEN / 2;

  logic            w_s2_adv;
  logic            w_s1_adv;
  logic            w_accept;
  logic            w_negate;
  logic [XLEN-1:0] w_lo;
  logic            w_lo_carry;
  logic [XLEN-1:0] w_hi;
  logic            w_unused_hi_carry;
  logic [XLEN-1:0] w_result;

  logic            r_s1_valid;
  logic [XLEN-1:0] r_s1_lo;
  logic            r_s1_carry;
  logic [XLEN-1:0] r_s1_phi;
  logic            r_s1_negate;
  mul_ctrl_t       r_s1_ctrl;
  logic            r_s1_isword;
  logic            r_o_valid;
  logic [XLEN-1:0] r_o_result;

  assign w_s2_adv        = !r_o_valid || i_mul_out_ready;
  assign w_s1_adv        = !r_s1_valid || w_s2_adv;
  assign w_accept        = i_mul_out_valid && w_s1_adv;
  assign o_mul_out_ready = w_s1_adv;
  assign o_mul_out_valid = r_o_valid;
  assign o_mul_out_result = r_o_result;

  assign w_negate = mul_negate(i_mul_out_control, i_mul_out_isword,
                               i_mul_out_signA, i_mul_out_signB);

  riscv_core_mul_neg_half #(.W(XLEN)) u_neg_lo (
    .i_data   (i_mul_out_product[XLEN-1:0]),
    .i_negate (w_negate),
    .i_carry  (1'b1),
    .o_data   (w_lo),
    .o_carry  (w_lo_carry)
  );

  // The carry out of the high half falls off the top of the 2*XLEN result.
  riscv_core_mul_neg_half #(.W(XLEN)) u_neg_hi (
    .i_data   (r_s1_phi),
    .i_negate (r_s1_negate),
    .i_carry  (r_s1_carry),
    .o_data   (w_hi),
    .o_carry  (w_unused_hi_carry)
  );

  always_comb begin
    w_result = w_hi;
    if (r_s1_isword == ISWORD_MULW) begin
      w_result = {{(XLEN-HALF){r_s1_lo[HALF-1]}}, r_s1_lo[HALF-1:0]};
    end else if (r_s1_ctrl == CTRL_MUL) begin
      w_result = r_s1_lo;
    end
  end

  always_ff @(posedge i_mul_out_clk or negedge i_mul_out_rst_n) begin
    if (!i_mul_out_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_lo     <= '0;
      r_s1_carry  <= 1'b0;
      r_s1_phi    <= '0;
      r_s1_negate <= 1'b0;
      r_s1_ctrl   <= CTRL_MUL;
      r_s1_isword <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_lo     <= w_lo;
        r_s1_carry  <= w_lo_carry;
        r_s1_phi    <= i_mul_out_product[2*XLEN-1:XLEN];
        r_s1_negate <= w_negate;
        r_s1_ctrl   <= i_mul_out_control;
        r_s1_isword <= i_mul_out_isword;
      end
    end
  end

  always_ff @(posedge i_mul_out_clk or negedge i_mul_out_rst_n) begin
    if (!i_mul_out_rst_n) begin
      r_o_valid  <= 1'b0;
      r_o_result <= '0;
    end else if (w_s2_adv) begin
      r_o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_o_result <= w_result;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_mul_out.sv
// Randomized and directed bench for riscv_core_mul_out with a 128-bit
// arithmetic reference model and an in-order expected-result queue.
module tb_riscv_core_mul_out;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_product;
  logic [1:0]   i_control;
  logic         i_isword;
  logic         i_signa;
  logic         i_signb;
  logic         o_valid;
  logic         i_ready;
  logic [63:0]  o_result;

  int n_vec  = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];
  logic        prev_stall;
  logic [63:0] prev_result;

  riscv_core_mul_out #(.XLEN(64)) dut (
    .i_mul_out_clk     (clk),
    .i_mul_out_rst_n   (rst_n),
    .i_mul_out_valid   (i_valid),
    .o_mul_out_ready   (o_ready),
    .i_mul_out_product (i_product),
    .i_mul_out_control (i_control),
    .i_mul_out_isword  (i_isword),
    .i_mul_out_signA   (i_signa),
    .i_mul_out_signB   (i_signb),
    .o_mul_out_valid   (o_valid),
    .i_mul_out_ready   (i_ready),
    .o_mul_out_result  (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed product as one 128-bit value, then pick the requested slice.
  function automatic logic [63:0] model(input logic [1:0] c, input logic w,
                                        input logic [127:0] p, input logic sa,
                                        input logic sb);
    logic         neg;
    logic [127:0] full;
    if (w) neg = sa ^ sb;
    else if (c == 2'd2) neg = sa;
    else if (c == 2'd3) neg = 1'b0;
    else neg = sa ^ sb;
    full = neg ? (128'd0 - p) : p;
    if (w) return {{32{full[31]}}, full[31:0]};
    if (c == 2'd0) return full[63:0];
    return full[127:64];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'd0, o_valid}, 64'd1);
        chk("hold_result", o_result, prev_result);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected no result", o_result);
        end else begin
          chk("result", o_result, exp_q.pop_front());
        end
      end
      prev_stall  = o_valid && !i_ready;
      prev_result = o_result;
      if (i_valid && o_ready)
        exp_q.push_back(model(i_control, i_isword, i_product, i_signa, i_signb));
    end
  end

  task automatic drive(input logic [1:0] c, input logic w, input logic [127:0] p,
                       input logic sa, input logic sb);
    i_valid   = 1'b1;
    i_control = c;
    i_isword  = w;
    i_product = p;
    i_signa   = sa;
    i_signb   = sb;
  endtask

  task automatic send_one(input string name, input logic [1:0] c, input logic w,
                          input logic [127:0] p, input logic sa, input logic sb,
                          input logic [63:0] exp);
    int cyc;
    i_ready = 1'b1;
    drive(c, w, p, sa, sb);
    @(posedge clk); #1;
    i_valid = 1'b0;
    cyc = 1;
    while (!o_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, 64'(cyc), 64'd2);
    chk(name, o_result, exp);
    @(posedge clk); #1;
  endtask

  task automatic fill_three(input logic [127:0] pa, input logic [127:0] pb,
                            input logic [127:0] pc);
    i_ready = 1'b0;
    drive(2'd0, 1'b0, pa, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(2'd1, 1'b0, pb, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(2'd3, 1'b0, pc, 1'b1, 1'b1);
    chk("fill_ready_drop", {63'd0, o_ready}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pa, pb, pc;
    logic [63:0]  ea, eb, ec;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_product = '0; i_control = 2'd0; i_isword = 1'b0; i_signa = 1'b0; i_signb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_result", o_result, 64'd0);
    chk("reset_ready", {63'd0, o_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", {63'd0, o_ready}, 64'd1);

    send_one("mul_neg15",  2'd0, 1'b0, 128'd15, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
    send_one("mulh_neg15", 2'd1, 1'b0, 128'd15, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    send_one("mulh_pos15", 2'd1, 1'b0, 128'd15, 1'b1, 1'b1, 64'h0);
    send_one("mul_pos15",  2'd0, 1'b0, 128'd15, 1'b1, 1'b1, 64'd15);
    send_one("mulhsu_sb1", 2'd2, 1'b0, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF);
    send_one("mulhsu_sb0", 2'd2, 1'b0, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF);
    send_one("mulh_zero",  2'd1, 1'b0, 128'd0, 1'b1, 1'b0, 64'h0);
    send_one("mulw_neg6",  2'd0, 1'b1, {64'hDEAD_BEEF_DEAD_BEEF, 64'd6}, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFA);
    send_one("mulhu_big",  2'd3, 1'b0, {64'h1234_5678_9ABC_DEF0, 64'h1}, 1'b1, 1'b1,
             64'h1234_5678_9ABC_DEF0);

    // Backpressure: two requests fill the pipe, the third waits.
    pa = 128'd100; pb = {64'd7, 64'd0}; pc = {64'hAAAA, 64'h5555};
    ea = model(2'd0, 1'b0, pa, 1'b1, 1'b0);
    eb = model(2'd1, 1'b0, pb, 1'b0, 1'b0);
    ec = model(2'd3, 1'b0, pc, 1'b1, 1'b1);
    fill_three(pa, pb, pc);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_ready", {63'd0, o_ready}, 64'd0);
      chk("stall_result", o_result, ea);
    end
    i_ready = 1'b1;
    #1;
    chk("drain_a", o_result, ea);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("drain_b_valid", {63'd0, o_valid}, 64'd1);
    chk("drain_b", o_result, eb);
    @(posedge clk); #1;
    chk("drain_c_valid", {63'd0, o_valid}, 64'd1);
    chk("drain_c", o_result, ec);
    @(posedge clk); #1;
    chk("drain_idle", {63'd0, o_valid}, 64'd0);

    // Reset in the middle of a stall discards everything in flight.
    fill_three(pa, pb, pc);
    @(posedge clk); #2;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_result", o_result, 64'd0);
    chk("midrst_ready", {63'd0, o_ready}, 64'd1);
    @(posedge clk); #3;
    rst_n   = 1'b1;
    i_ready = 1'b1;
    #1;
    chk("rel_ready", {63'd0, o_ready}, 64'd1);
    @(posedge clk); #1;
    chk("rel_valid", {63'd0, o_valid}, 64'd0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 600; k++) begin
      i_valid   = ($urandom_range(0, 9) < 7);
      i_control = 2'($urandom_range(0, 3));
      i_isword  = ($urandom_range(0, 4) == 0);
      i_product = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) i_product[63:0] = 64'd0;
      i_signa   = 1'($urandom_range(0, 1));
      i_signb   = 1'($urandom_range(0, 1));
      i_ready   = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    chk("final_idle", {63'd0, o_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
